// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer.
// Holds the sequencer state encoding, the phase counter width and the
// default values of every sequencer parameter so that the top, its
// phase timer and the bus interface all agree on them.
package pc_seq_pkg;

   typedef enum logic {
      RUN    = 1'b0,
      HALTED = 1'b1
   } seq_state_t;

   // Width of the phase output; MULTI_CYC is limited to 2..15 by it.
   localparam int PHASE_W          = 4;

   localparam int DEF_ADDR_W       = 5;
   localparam int DEF_FUNC_W       = 4;
   localparam int DEF_MULTI_THRESH = 2;
   localparam int DEF_MULTI_CYC    = 5;
   localparam int DEF_RESET_ADDR   = 0;
   localparam int DEF_WRAP_EN      = 1;

endpackage

// File: rtl/pc_sequencer_if.sv
// Bus bundle between a controller and the program-counter sequencer.
// master modport (controller side):
//    drives  en, func, load, load_addr, halt_req
//    reads   address, phase, busy, step, wrapped, halted
// slave modport (sequencer side): the same signals, opposite directions.
interface pc_sequencer_if
   import pc_seq_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int FUNC_W = DEF_FUNC_W
);
   logic               en;
   logic [FUNC_W-1:0]  func;
   logic               load;
   logic [ADDR_W-1:0]  load_addr;
   logic               halt_req;
   logic [ADDR_W-1:0]  address;
   logic [PHASE_W-1:0] phase;
   logic               busy;
   logic               step;
   logic               wrapped;
   logic               halted;

   modport master (
      output en, func, load, load_addr, halt_req,
      input  address, phase, busy, step, wrapped, halted
   );

   modport slave (
      input  en, func, load, load_addr, halt_req,
      output address, phase, busy, step, wrapped, halted
   );
endinterface

// File: rtl/pc_sequencer_cycle_timer.sv
// Phase counter for multi-cycle instructions.
// Ports:
//    clk, rst  - falling-edge clock, asynchronous active-high reset
//    clear     - force count to 0 (wins over enable)
//    enable    - advance count; rolls from CYC-1 back to 0
//    count     - current phase
//    tc        - terminal count flag (count == CYC-1)
module cycle_timer
   import pc_seq_pkg::*;
#(
   parameter int CYC = DEF_MULTI_CYC
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clear,
   input  logic               enable,
   output logic [PHASE_W-1:0] count,
   output logic               tc
);
   localparam logic [PHASE_W-1:0] LAST = PHASE_W'(CYC - 1);

   logic [PHASE_W-1:0] count_reg;

   always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
         count_reg <= '0;
      end else if (clear) begin
         count_reg <= '0;
      end else if (enable) begin
         count_reg <= (count_reg == LAST) ? '0 : count_reg + PHASE_W'(1);
      end
   end

   assign count = count_reg;
   assign tc    = (count_reg == LAST);
endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer.
// Steps an instruction address on every falling clock edge. Single-cycle
// instructions (func < MULTI_THRESH) advance at once; multi-cycle ones hold
// the address for MULTI_CYC edges while phase counts. Supports stall (en),
// branch (load), halt (halt_req) and wrap/stop at the top address.
// Ports:
//    clk  - clock, state changes on its falling edge
//    rst  - asynchronous active-high reset
//    bus  - pc_sequencer_if.slave: en, func, load, load_addr, halt_req in;
//           address, phase, busy, step, wrapped, halted out
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int ADDR_W       = DEF_ADDR_W,
   parameter int FUNC_W       = DEF_FUNC_W,
   parameter int MULTI_THRESH = DEF_MULTI_THRESH,
   parameter int MULTI_CYC    = DEF_MULTI_CYC,
   parameter int RESET_ADDR   = DEF_RESET_ADDR,
   parameter int WRAP_EN      = DEF_WRAP_EN
) (
   input logic           clk,
   input logic           rst,
   pc_sequencer_if.slave bus
);
   localparam logic [ADDR_W-1:0] TOP_ADDR = '1;

   seq_state_t         state_reg;
   logic [ADDR_W-1:0]  address_reg;
   logic [FUNC_W-1:0]  func_lat_reg;
   logic               step_reg;
   logic               wrapped_reg;

   logic [PHASE_W-1:0] phase;
   logic               tc;
   logic               idle_phase;
   logic               multi_live;
   logic               multi_lat;
   logic               running;
   logic               advancing;
   logic               timer_clear;
   logic               timer_enable;

   assign idle_phase = (phase == '0);
   // Live opcode decides at phase 0; afterwards only the latched one counts.
   assign multi_live = (32'(bus.func) >= $unsigned(MULTI_THRESH));
   assign multi_lat  = (32'(func_lat_reg) >= $unsigned(MULTI_THRESH));

   // Normal sequencing only when nothing of higher priority is asserted.
   assign running = (state_reg == RUN) && !bus.load && !bus.halt_req && bus.en;

   assign timer_clear  = bus.load || ((state_reg == RUN) && bus.halt_req);
   assign timer_enable = running && (idle_phase ? multi_live : multi_lat);
   assign advancing    = running && (idle_phase ? !multi_live : (multi_lat && tc));

   cycle_timer #(
      .CYC (MULTI_CYC)
   ) u_timer (
      .clk    (clk),
      .rst    (rst),
      .clear  (timer_clear),
      .enable (timer_enable),
      .count  (phase),
      .tc     (tc)
   );

   always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= RUN;
         address_reg  <= ADDR_W'(RESET_ADDR);
         func_lat_reg <= '0;
         step_reg     <= 1'b0;
         wrapped_reg  <= 1'b0;
      end else begin
         step_reg    <= 1'b0;
         wrapped_reg <= 1'b0;
         if (bus.load) begin
            // Branch aborts any instruction in flight and leaves HALTED.
            state_reg   <= RUN;
            address_reg <= bus.load_addr;
            step_reg    <= 1'b1;
         end else if (state_reg == RUN) begin
            if (bus.halt_req) begin
               state_reg <= HALTED;
            end else if (bus.en) begin
               if (idle_phase) begin
                  func_lat_reg <= bus.func;
               end
               if (advancing) begin
                  if (address_reg != TOP_ADDR) begin
                     address_reg <= address_reg + ADDR_W'(1);
                     step_reg    <= 1'b1;
                  end else if (WRAP_EN != 0) begin
                     address_reg <= '0;
                     step_reg    <= 1'b1;
                     wrapped_reg <= 1'b1;
                  end else begin
                     // No wrap: park on the top address.
                     state_reg <= HALTED;
                  end
               end
            end
         end
      end
   end

   assign bus.address = address_reg;
   assign bus.phase   = phase;
   assign bus.busy    = !idle_phase;
   assign bus.step    = step_reg;
   assign bus.wrapped = wrapped_reg;
   assign bus.halted  = (state_reg == HALTED);
endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, address width.
REQ-002 SHALL have parameter FUNC_W, default 4, func opcode width.
REQ-003 SHALL have parameter MULTI_THRESH, default 2; func >= MULTI_THRESH (unsigned) is a multi-cycle instruction.
REQ-004 SHALL have parameter MULTI_CYC, default 5 (legal range 2..15), cycles per multi-cycle instruction.
REQ-005 SHALL have parameter RESET_ADDR, default 0, address after reset.
REQ-006 SHALL have parameter WRAP_EN, default 1; 1 = wrap at top address, 0 = stop at top address.
REQ-007 SHALL have port clk, input, 1, the single clock; all state updates on its falling edge.
REQ-008 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-009 SHALL have port en, input, 1, advance enable; low = stall.
REQ-010 SHALL have port func, input, FUNC_W, opcode of the instruction at the current address.
REQ-011 SHALL have port load, input, 1, branch request.
REQ-012 SHALL have port load_addr, input, ADDR_W, branch target.
REQ-013 SHALL have port halt_req, input, 1, halt request.
REQ-014 SHALL have port address, output, ADDR_W, current instruction address (registered).
REQ-015 SHALL have port phase, output, 4, cycle index within the current instruction.
REQ-016 SHALL have port busy, output, 1, high while a multi-cycle instruction is in progress (phase != 0).
REQ-017 SHALL have port step, output, 1, one-cycle pulse on every address change.
REQ-018 SHALL have port wrapped, output, 1, one-cycle pulse when address wraps to 0.
REQ-019 SHALL have port halted, output, 1, high while in HALTED.

Function
REQ-020 SHALL implement states RUN and HALTED.
REQ-021 SHALL apply per-edge priority: rst > load > halt_req > en=0 > normal sequencing.
REQ-022 SHALL, in RUN with en=1 and phase=0, latch func; func < MULTI_THRESH gives address+1 on the same edge.
REQ-023 SHALL, for a latched multi-cycle func, hold address while phase counts 1..MULTI_CYC-1; on the edge after phase MULTI_CYC-1, phase=0 and address+1 (address held for exactly MULTI_CYC edges).
REQ-024 SHALL ignore func while phase != 0 and use the latched value.
REQ-025 SHALL, with en=0, freeze address, phase and latched func; step=0.
REQ-026 SHALL, on load=1 in any state, set address=load_addr, phase=0, enter RUN, step=1, and abort any in-progress instruction.
REQ-027 SHALL, on halt_req=1 without load, enter HALTED, freeze address and set phase=0; only load or rst exits HALTED.
REQ-028 SHALL, on increment from 2^ADDR_W-1: with WRAP_EN=1, set address=0 and wrapped=1; with WRAP_EN=0, hold address, enter HALTED and keep step=0.
REQ-029 SHALL perform address arithmetic modulo 2^ADDR_W with no other saturation.
REQ-030 SHALL register step and wrapped, each high for exactly one cycle per event.

Reset
REQ-031 SHALL, on rst high, immediately set address=RESET_ADDR, phase=0, latched func=0, state=RUN, and step=wrapped=halted=busy=0.
REQ-032 SHALL discard an in-progress multi-cycle instruction on reset; the first falling edge after rst deasserts sequences normally.

Structure
REQ-033 SHALL place the state enum (RUN, HALTED) and parameter defaults in shared package pc_seq_pkg.
REQ-034 SHALL implement the phase counter (clear, enable, terminal-count flag) as sub-module cycle_timer.

Verification (ADDR_W=5, MULTI_CYC=5, MULTI_THRESH=2)
REQ-035 SHALL cover: rst, then func=0, en=1, 3 edges -> address 1,2,3; step high each edge.
REQ-036 SHALL cover: address=3, func=4 -> address 3 for 5 edges, phase 1,2,3,4,0, busy high 4 cycles, address=4 after 5th edge.
REQ-037 SHALL cover: load=1, load_addr=17 at phase 2 -> next edge address=17, phase=0, busy=0, step=1.
REQ-038 SHALL cover: address=31, func=0, WRAP_EN=1 -> address 0, wrapped=1; with WRAP_EN=0 -> address 31, halted=1.
REQ-039 SHALL cover: en=0 for 2 edges at phase 3 -> address and phase frozen; after en=1, instruction completes with phase 4, then 0.
REQ-040 SHALL cover: rst pulsed between edges at phase 2, address 9 -> address=0, phase=0 before the next edge.
